// File: rtl/qerv_alu_seq.sv
// Runs one full 32-bit ALU operation through a W-bit-per-cycle qerv ALU.
// The sequencer shifts the operands out LSB-first and collects the result into a valid/ready response.
module qerv_alu_seq #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [2:0]   i_req_op,
  input  logic [31:0]  i_req_rs1,
  input  logic [31:0]  i_req_op_b,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [31:0]  o_rsp_rd,
  output logic         o_rsp_cmp,
  output logic         o_alu_en,
  output logic         o_alu_cnt0,
  output logic         o_alu_sub,
  output logic         o_alu_cmp_eq,
  output logic         o_alu_cmp_sig,
  output logic [1:0]   o_alu_bool_op,
  output logic [2:0]   o_alu_rd_sel,
  output logic [W-1:0] o_alu_rs1,
  output logic [W-1:0] o_alu_op_b,
  output logic [W-1:0] o_alu_buf,
  input  logic [W-1:0] i_alu_rd,
  input  logic         i_alu_cmp
);
  localparam int unsigned N  = 32 / W;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_EQ   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [31:0]   r_rs1, r_op_b, r_res;
  logic          r_ready, r_rsp_valid, r_rsp_cmp, r_en, r_cnt0;
  logic          r_sub, r_cmp_eq, r_cmp_sig;
  logic [1:0]    r_bool_op;
  logic [2:0]    r_rd_sel;

  logic          w_sub, w_cmp_eq, w_cmp_sig, w_is_cmp;
  logic [1:0]    w_bool_op;
  logic [2:0]    w_rd_sel;
  logic [31:0]   w_res_shift;

  // ALU control decode of an incoming opcode; registered when the request is latched
  always_comb begin
    w_sub     = 1'b0;
    w_cmp_eq  = 1'b0;
    w_cmp_sig = 1'b0;
    w_bool_op = 2'b01;
    w_rd_sel  = 3'b000;
    case (i_req_op)
      OP_ADD:  w_rd_sel = 3'b001;
      OP_SUB:  begin w_sub = 1'b1; w_rd_sel = 3'b001; end
      OP_SLT:  begin w_sub = 1'b1; w_cmp_sig = 1'b1; end
      OP_SLTU: w_sub = 1'b1;
      OP_EQ:   begin w_sub = 1'b1; w_cmp_eq = 1'b1; end
      OP_XOR:  begin w_bool_op = 2'b00; w_rd_sel = 3'b100; end
      OP_OR:   begin w_bool_op = 2'b10; w_rd_sel = 3'b100; end
      default: begin w_bool_op = 2'b11; w_rd_sel = 3'b100; end
    endcase
  end

  assign w_is_cmp    = (r_op == OP_SLT) || (r_op == OP_SLTU) || (r_op == OP_EQ);
  assign w_res_shift = {i_alu_rd, r_res[31:W]};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_rs1       <= '0;
      r_op_b      <= '0;
      r_res       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_cmp   <= 1'b0;
      r_en        <= 1'b0;
      r_cnt0      <= 1'b0;
      r_sub       <= 1'b0;
      r_cmp_eq    <= 1'b0;
      r_cmp_sig   <= 1'b0;
      r_bool_op   <= 2'b01;
      r_rd_sel    <= 3'b001;
    end else begin
      r_cnt0 <= 1'b0;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_op      <= i_req_op;
          r_rs1     <= i_req_rs1;
          r_op_b    <= i_req_op_b;
          r_sub     <= w_sub;
          r_cmp_eq  <= w_cmp_eq;
          r_cmp_sig <= w_cmp_sig;
          r_bool_op <= w_bool_op;
          r_rd_sel  <= w_rd_sel;
          r_ready   <= 1'b0;
          r_state   <= S_PREP;
        end
        // ALU idles one cycle so its carry loads the sub value before beat 0
        S_PREP: begin
          r_en    <= 1'b1;
          r_cnt0  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_rs1  <= r_rs1 >> W;
          r_op_b <= r_op_b >> W;
          r_res  <= w_res_shift;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_en        <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_cmp   <= w_is_cmp & i_alu_cmp;
            r_state     <= S_DONE;
            if (w_is_cmp) r_res <= (r_op == OP_EQ) ? 32'd0 : {31'd0, i_alu_cmp};
          end
        end
        S_DONE: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready   = r_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rd      = r_res;
  assign o_rsp_cmp     = r_rsp_cmp;
  assign o_alu_en      = r_en;
  assign o_alu_cnt0    = r_cnt0;
  assign o_alu_sub     = r_sub;
  assign o_alu_cmp_eq  = r_cmp_eq;
  assign o_alu_cmp_sig = r_cmp_sig;
  assign o_alu_bool_op = r_bool_op;
  assign o_alu_rd_sel  = r_rd_sel;
  assign o_alu_rs1     = r_rs1[W-1:0];
  assign o_alu_op_b    = r_op_b[W-1:0];
  assign o_alu_buf     = W'(0);
endmodule

// File: tb/tb_qerv_alu_seq.sv
// Bench for qerv_alu_seq: a W=1 and a W=4 instance, each driving a behavioural serial ALU,
// with results checked against plain 32-bit arithmetic.
module tb_qerv_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0, dsel = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = '0, req_opb = '0;
  int nchk = 0, nfail = 0;

  // ---------------- W=1 instance and its ALU ----------------
  logic        a_ready, a_rv, a_rcmp, a_en, a_cnt0, a_sub, a_eq, a_sig, a_cmp;
  logic [31:0] a_rd;
  logic [1:0]  a_bool;
  logic [2:0]  a_sel;
  logic [0:0]  a_rs1, a_opb, a_buf, a_ard;
  qerv_alu_seq #(.W(1)) u_w1 (
    .clk(clk), .i_rst(rst), .i_req_valid(req_valid & ~dsel), .o_req_ready(a_ready),
    .i_req_op(req_op), .i_req_rs1(req_rs1), .i_req_op_b(req_opb),
    .o_rsp_valid(a_rv), .i_rsp_ready(rsp_ready & ~dsel), .o_rsp_rd(a_rd), .o_rsp_cmp(a_rcmp),
    .o_alu_en(a_en), .o_alu_cnt0(a_cnt0), .o_alu_sub(a_sub), .o_alu_cmp_eq(a_eq),
    .o_alu_cmp_sig(a_sig), .o_alu_bool_op(a_bool), .o_alu_rd_sel(a_sel),
    .o_alu_rs1(a_rs1), .o_alu_op_b(a_opb), .o_alu_buf(a_buf), .i_alu_rd(a_ard), .i_alu_cmp(a_cmp));

  // ---------------- W=4 instance and its ALU ----------------
  logic        b_ready, b_rv, b_rcmp, b_en, b_cnt0, b_sub, b_eq, b_sig, b_cmp;
  logic [31:0] b_rd;
  logic [1:0]  b_bool;
  logic [2:0]  b_sel;
  logic [3:0]  b_rs1, b_opb, b_buf, b_ard;
  qerv_alu_seq #(.W(4)) u_w4 (
    .clk(clk), .i_rst(rst), .i_req_valid(req_valid & dsel), .o_req_ready(b_ready),
    .i_req_op(req_op), .i_req_rs1(req_rs1), .i_req_op_b(req_opb),
    .o_rsp_valid(b_rv), .i_rsp_ready(rsp_ready & dsel), .o_rsp_rd(b_rd), .o_rsp_cmp(b_rcmp),
    .o_alu_en(b_en), .o_alu_cnt0(b_cnt0), .o_alu_sub(b_sub), .o_alu_cmp_eq(b_eq),
    .o_alu_cmp_sig(b_sig), .o_alu_bool_op(b_bool), .o_alu_rd_sel(b_sel),
    .o_alu_rs1(b_rs1), .o_alu_op_b(b_opb), .o_alu_buf(b_buf), .i_alu_rd(b_ard), .i_alu_cmp(b_cmp));

  // One ALU beat of width w: returns {carry_out, rd slice}
  function automatic logic [8:0] beat(input int w, input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic sub, input logic [1:0] bop,
                                      input logic [2:0] sel);
    logic [7:0] m, bl, r;
    logic [8:0] s;
    m = 8'((9'd1 << w) - 9'd1);
    s = {1'b0, a & m} + {1'b0, (b ^ {8{sub}}) & m} + 9'(c);
    case (bop)
      2'b00:   bl = a ^ b;
      2'b10:   bl = a | b;
      2'b11:   bl = a & b;
      default: bl = 8'd0;
    endcase
    r = (sel == 3'b001) ? s[7:0] : (sel == 3'b100) ? bl : 8'd0;
    return {s[w], r & m};
  endfunction

  function automatic logic cmpf(input logic [31:0] a, input logic [31:0] b, input logic eq, input logic sig);
    if (eq) return a == b;
    if (sig) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  logic [31:0] a_acc = '0, a_bacc = '0, a_cur, a_bcur;
  int a_k = 0, a_kc;
  logic a_c = 1'b0;
  logic [8:0] a_bt;
  always_comb begin
    a_kc   = a_cnt0 ? 0 : a_k;
    a_cur  = (a_cnt0 ? 32'd0 : a_acc)  | (32'(a_rs1) << a_kc);
    a_bcur = (a_cnt0 ? 32'd0 : a_bacc) | (32'(a_opb) << a_kc);
    a_bt   = beat(1, 8'(a_rs1), 8'(a_opb), a_c, a_sub, a_bool, a_sel);
    a_ard  = a_bt[0:0];
    a_cmp  = cmpf(a_cur, a_bcur, a_eq, a_sig);
  end
  always @(posedge clk) begin
    a_c <= a_en ? a_bt[8] : a_sub;
    if (a_en) begin a_acc <= a_cur; a_bacc <= a_bcur; a_k <= a_kc + 1; end
  end

  logic [31:0] b_acc = '0, b_bacc = '0, b_cur, b_bcur;
  int b_k = 0, b_kc;
  logic b_c = 1'b0;
  logic [8:0] b_bt;
  always_comb begin
    b_kc   = b_cnt0 ? 0 : b_k;
    b_cur  = (b_cnt0 ? 32'd0 : b_acc)  | (32'(b_rs1) << (4 * b_kc));
    b_bcur = (b_cnt0 ? 32'd0 : b_bacc) | (32'(b_opb) << (4 * b_kc));
    b_bt   = beat(4, 8'(b_rs1), 8'(b_opb), b_c, b_sub, b_bool, b_sel);
    b_ard  = b_bt[3:0];
    b_cmp  = cmpf(b_cur, b_bcur, b_eq, b_sig);
  end
  always @(posedge clk) begin
    b_c <= b_en ? b_bt[8] : b_sub;
    if (b_en) begin b_acc <= b_cur; b_bacc <= b_bcur; b_k <= b_kc + 1; end
  end

  // Selected-instance view
  logic m_ready, m_rv, m_rcmp, m_en, m_cnt0;
  logic [31:0] m_rd;
  always_comb begin
    m_ready = dsel ? b_ready : a_ready;
    m_rv    = dsel ? b_rv    : a_rv;
    m_rcmp  = dsel ? b_rcmp  : a_rcmp;
    m_en    = dsel ? b_en    : a_en;
    m_cnt0  = dsel ? b_cnt0  : a_cnt0;
    m_rd    = dsel ? b_rd    : a_rd;
  end

  // Reference results from plain arithmetic
  function automatic logic [31:0] ref_rd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return 32'd0;
      3'd5: return a ^ b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd2: return $signed(a) < $signed(b);
      3'd3: return a < b;
      3'd4: return a == b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the selected instance (called at a negedge), hold response for `hold` cycles
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n, lat, c0;
    logic [31:0] erd;
    logic ecmp;
    n = dsel ? 8 : 32;
    erd = ref_rd(op, a, b);
    ecmp = ref_cmp(op, a, b);
    chk("req_ready_idle", 32'(m_ready), 32'd1);
    req_op = op; req_rs1 = a; req_opb = b; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_op = 3'($urandom); req_rs1 = $urandom; req_opb = $urandom;
    lat = 0; c0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (m_cnt0) c0++;
      if (m_rv) break;
    end
    req_valid = 1'b0;
    chk("latency", 32'(lat), 32'(n + 2));
    chk("cnt0_pulses", 32'(c0), 32'd1);
    chk("rsp_rd", m_rd, erd);
    chk("rsp_cmp", 32'(m_rcmp), 32'(ecmp));
    chk("req_ready_done", 32'(m_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(m_rv), 32'd1);
      chk("hold_rd", m_rd, erd);
      chk("hold_req_ready", 32'(m_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after", 32'(m_rv), 32'd0);
    chk("req_ready_after", 32'(m_ready), 32'd1);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(a_ready), 32'd1);
    chk("rst_rsp_valid", 32'(a_rv), 32'd0);
    chk("rst_rsp_cmp", 32'(a_rcmp), 32'd0);
    chk("rst_alu_en", 32'(a_en), 32'd0);
    chk("rst_cnt0", 32'(a_cnt0), 32'd0);
    chk("rst_rsp_rd", a_rd, 32'd0);
    chk("rst_ctrl", {26'd0, a_sub, a_bool, a_sel}, {26'd0, 1'b0, 2'b01, 3'b001});
    chk("rst_buf", 32'(a_buf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(3'd0, 32'h00000005, 32'h00000003, 0);
    do_op(3'd1, 32'h00000000, 32'h00000001, 0);
    do_op(3'd1, 32'h80000000, 32'h00000001, 1);
    do_op(3'd2, 32'hFFFFFFFF, 32'h00000001, 0);
    do_op(3'd3, 32'hFFFFFFFF, 32'h00000001, 0);
    do_op(3'd4, 32'h12345678, 32'h12345678, 0);
    do_op(3'd4, 32'h12345678, 32'h12345679, 0);
    do_op(3'd7, 32'hF0F0F0F0, 32'hFF00FF00, 0);
    do_op(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 0);
    do_op(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 5);

    // Reset in the middle of RUN beat 10: no response may follow
    req_op = 3'd0; req_rs1 = 32'h11111111; req_opb = 32'h22222222; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrun_en", 32'(a_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", 32'(a_ready), 32'd1);
    chk("abort_alu_en", 32'(a_en), 32'd0);
    chk("abort_rsp_valid", 32'(a_rv), 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (a_rv) seen++; end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    do_op(3'd0, 32'h00000001, 32'h00000001, 0);

    for (int i = 0; i < 30; i++)
      do_op(3'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'h00000000 : $urandom, int'($urandom_range(0, 2)));

    dsel = 1'b1;
    @(negedge clk);
    do_op(3'd0, 32'h7FFFFFFF, 32'h00000001, 0);
    do_op(3'd1, 32'h80000000, 32'h00000001, 0);
    do_op(3'd2, 32'h80000000, 32'h7FFFFFFF, 2);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] x;
      x = $urandom;
      do_op(3'($urandom), x, ($urandom_range(0, 3) == 0) ? x : $urandom, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/qerv_alu_seq.md
Name: qerv_alu_seq

Overview:
Sequencer that runs one complete 32-bit ALU operation through the W-bit-per-cycle qerv ALU. It accepts a request with full 32-bit operands and an opcode, drives the ALU control and operand slices LSB-first for 32/W cycles, and reassembles the result. It returns rd and the comparison flag on a valid/ready response port. It sits between a requester (debug/accelerator port or test harness) and a dedicated ALU instance.

Parameters:
W, 1, ALU datapath width per cycle; legal values 1, 2, 4, 8. N = 32/W beats per operation.

Ports:
clk  in  1  clock; all logic on posedge
i_rst  in  1  synchronous, active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  high only in IDLE
i_req_op  in  3  000 ADD, 001 SUB, 010 SLT, 011 SLTU, 100 EQ, 101 XOR, 110 OR, 111 AND
i_req_rs1  in  32  operand A
i_req_op_b  in  32  operand B
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accept
o_rsp_rd  out  32  result
o_rsp_cmp  out  1  final compare flag (lt or eq); 0 for non-compare ops
o_alu_en  out  1  ALU enable
o_alu_cnt0  out  1  first beat marker
o_alu_sub, o_alu_cmp_eq, o_alu_cmp_sig  out  1 each  ALU controls
o_alu_bool_op  out  2  ALU bool select
o_alu_rd_sel  out  3  ALU result select
o_alu_rs1, o_alu_op_b, o_alu_buf  out  W each  operand slices; buf tied to 0
i_alu_rd  in  W  ALU result slice
i_alu_cmp  in  1  ALU compare output

Behaviour:
- States: IDLE, PREP, RUN, DONE. Beat counter cnt, log2(N) bits.
- Reset (dominates everything, including mid-operation): state IDLE, cnt 0, latched op ADD, operand and result shift registers 0, o_rsp_valid 0, o_rsp_cmp 0, o_alu_en 0, o_alu_cnt0 0. An aborted operation produces no response.
- IDLE: o_req_ready 1. On i_req_valid: latch op, rs1, op_b; go to PREP.
- PREP (1 cycle): o_alu_en 0 with o_alu_sub already driven from the latched op, so the ALU carry register preloads the sub value before beat 0.
- RUN (N cycles): o_alu_en 1; o_alu_cnt0 = (cnt==0). Operand slices are the low W bits of the rs1/op_b shift registers, which shift right by W each beat. The result register shifts right by W with i_alu_rd entering at bits [31:32-W]. On cnt==N-1: capture i_alu_cmp, go to DONE, and clear cnt.
- DONE: o_rsp_valid 1; o_rsp_rd and o_rsp_cmp stay stable until i_rsp_ready, then return to IDLE. Latency from the accept cycle T: o_rsp_valid is first high at T+N+2. Throughput: one op per N+3 cycles minimum.
- ALU controls are a function of the latched op and are held constant in every state:
  - sub = 1 for SUB/SLT/SLTU/EQ.
  - cmp_sig = 1 only for SLT.
  - cmp_eq = 1 only for EQ.
  - bool_op: XOR 00, OR 10, AND 11, otherwise 01.
  - rd_sel: ADD/SUB 001, XOR/OR/AND 100, compares 000.
- Compare ops: o_rsp_rd = {31'b0, captured cmp}, except EQ where rd = 0. The ALU slt path is not used. o_rsp_cmp = captured cmp for SLT/SLTU/EQ, else 0.
- i_req_* are ignored outside IDLE. i_rsp_ready is ignored outside DONE.

Test Plan:
- W=1, ADD 0x00000005 + 0x00000003, i_rsp_ready=1 -> o_rsp_rd=0x00000008, o_rsp_cmp=0, o_rsp_valid first high at accept+34.
- SUB 0x00000000 - 0x00000001 -> rd 0xFFFFFFFF. SUB 0x80000000 - 0x00000001 -> rd 0x7FFFFFFF. This checks the PREP carry preload.
- SLT rs1=0xFFFFFFFF, op_b=0x00000001 -> rd 0x1, cmp 1. SLTU on the same operands -> rd 0x0, cmp 0. EQ 0x12345678 vs 0x12345678 -> cmp 1, rd 0. EQ 0x12345678 vs 0x12345679 -> cmp 0.
- rs1=0xF0F0F0F0, op_b=0xFF00FF00 -> AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0. Hold i_rsp_ready low 5 cycles in DONE -> o_rsp_valid held, data stable, o_req_ready 0.
- Assert i_rst at RUN beat 10 -> next cycle IDLE, o_req_ready 1, o_alu_en 0, o_rsp_valid 0. A following ADD 1+1 returns 2.
- W=4 build: ADD 0x7FFFFFFF + 0x00000001 -> rd 0x80000000 at accept+10. o_alu_cnt0 is high on exactly one cycle per op.
